// File: rtl/aha_reset_req_pkg.sv
// aha_reset_req_pkg: state encoding, default synchroniser depth and counter-width check
// shared by the reset-request initiator.
package aha_reset_req_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ASSERT = 2'b01, RELEASE = 2'b10} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic bit cnt_w_ok(input int cnt_w, input int timeout_cycles);
    return (cnt_w > 30) || ((1 << cnt_w) > timeout_cycles);
  endfunction
endpackage

// File: rtl/aha_reset_req_ack_sync.sv
// aha_reset_req_ack_sync: SYNC_STAGES-flop synchroniser bringing the asynchronous ACK into CLK.
module aha_reset_req_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic poresetn_sync,
  input  logic i_ack,
  output logic o_ack_s
);
  logic [SYNC_STAGES-1:0] r_sync;
  always_ff @(posedge CLK or negedge poresetn_sync) begin
    if (!poresetn_sync) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], i_ack};
  end
  assign o_ack_s = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/aha_reset_req_ctrl.sv
// aha_reset_req_ctrl: four-phase REQ/ACK reset-request initiator with one-deep trigger coalescing.
// Define AHA_RESET_REQ_TIMEOUT_EN to add the per-phase timeout counter, abort paths and sticky ERR.
module aha_reset_req_ctrl
  import aha_reset_req_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic CLK,
  input  logic poresetn_sync,
  input  logic TRIG,
  input  logic ACK,
  input  logic ERR_CLR,
  output logic REQ,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 4 || !cnt_w_ok(CNT_W, TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("aha_reset_req_ctrl: illegal parameter set");
  end
  state_t r_state, w_state_nxt;
  logic r_pend, w_pend_nxt, r_req, r_busy, r_done, w_done_nxt;
  logic w_ack_s, w_tmo, w_abrt;
  aha_reset_req_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .CLK(CLK),
    .poresetn_sync(poresetn_sync),
    .i_ack(ACK),
    .o_ack_s(w_ack_s)
  );
`ifdef AHA_RESET_REQ_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic r_err, r_abrt;
  // a timeout only aborts when the awaited ACK level has not already arrived
  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                 ((r_state == ASSERT && !w_ack_s) || (r_state == RELEASE && w_ack_s));
  assign w_abrt = r_abrt;
  always_ff @(posedge CLK or negedge poresetn_sync) begin
    if (!poresetn_sync) begin
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_abrt <= 1'b0;
    end else begin
      r_cnt  <= (w_state_nxt != r_state) ? '0 :
                (r_state != IDLE && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
      r_err  <= w_tmo | (r_err & ~ERR_CLR);
      r_abrt <= (r_state == ASSERT && w_tmo) ? 1'b1 : (w_state_nxt == IDLE) ? 1'b0 : r_abrt;
    end
  end
  assign ERR = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = ERR_CLR;
  assign w_tmo  = 1'b0;
  assign w_abrt = 1'b0;
  assign ERR    = 1'b0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend | TRIG;
    w_done_nxt  = 1'b0;
    if (r_state == IDLE) begin
      if (!w_ack_s && (TRIG || r_pend)) begin
        w_state_nxt = ASSERT;
        w_pend_nxt  = 1'b0;
      end
    end else if (r_state == ASSERT) begin
      if (w_ack_s || w_tmo) w_state_nxt = RELEASE;
    end else if (!w_ack_s || w_tmo) begin
      w_state_nxt = IDLE;
      w_done_nxt  = !w_ack_s && !w_abrt;
    end
  end
  always_ff @(posedge CLK or negedge poresetn_sync) begin
    if (!poresetn_sync) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_req   <= (w_state_nxt == ASSERT);
      r_busy  <= (w_state_nxt != IDLE) | w_pend_nxt;
      r_done  <= w_done_nxt;
    end
  end
  assign REQ  = r_req;
  assign BUSY = r_busy;
  assign DONE = r_done;
endmodule
